// File: rtl/pc_unit_if.sv
// Bundles the redirect inputs and PC-stage outputs of the program-counter stage.
// The master side (fetch/decode control) drives stall and redirects.
// The slave side (pc_unit) returns the fetch address and status.
interface pc_unit_if;
  logic        stall;
  logic        branch_taken;
  logic [31:0] Add_ALUresult;
  logic        jump;
  logic [25:0] instr_index;
  logic        jump_reg;
  logic [31:0] rs_data;
  logic [31:0] pc;
  logic [31:0] PCplus4;
  logic        delay_slot;
  logic        active;

  modport master (
    output stall, branch_taken, Add_ALUresult, jump, instr_index, jump_reg, rs_data,
    input  pc, PCplus4, delay_slot, active
  );

  modport slave (
    input  stall, branch_taken, Add_ALUresult, jump, instr_index, jump_reg, rs_data,
    output pc, PCplus4, delay_slot, active
  );
endinterface

// File: rtl/pc_unit.sv
// Program counter with a one-instruction branch delay slot and halt-on-jump-to-zero.
// Latency: delay slot 1 edge after the redirect is sampled, target 2 unstalled edges after.
// Backpressure: stall freezes every register; a redirect seen on a stalled edge is dropped.
module pc_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000
) (
  input  logic          clk,
  input  logic          rst_n,
  pc_unit_if.slave      pc_if
);

  typedef enum logic {NORMAL, DELAY} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] target_q, target_d;
  logic        active_q, active_d;
  logic [31:0] pc_plus4;
  logic        redirect;
  logic [31:0] sel_target;

  assign pc_plus4 = pc_q + 32'd4;
  assign redirect = pc_if.jump_reg | pc_if.jump | pc_if.branch_taken;

  // Redirect target selection: jump_reg wins over jump, jump over branch.
  always_comb begin
    sel_target = pc_if.Add_ALUresult;
    if (pc_if.jump_reg) begin
      sel_target = pc_if.rs_data;
    end else if (pc_if.jump) begin
      sel_target = {pc_plus4[31:28], pc_if.instr_index, 2'b00};
    end
  end

  // Next-state logic: sequential fetch, capture a redirect, or jump to the held target.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    target_d = target_q;
    active_d = active_q;
    if (!pc_if.stall && active_q) begin
      case (state_q)
        NORMAL: begin
          pc_d = pc_plus4;
          if (redirect) begin
            target_d = sel_target;
            state_d  = DELAY;
          end
        end
        DELAY: begin
          // A redirect in the delay slot is not honoured, so inputs are ignored here.
          pc_d    = target_q;
          state_d = NORMAL;
          if (target_q == 32'd0) begin
            active_d = 1'b0;
          end
        end
        default: state_d = NORMAL;
      endcase
    end
  end

  // State registers; reset discards any pending target.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= NORMAL;
      pc_q     <= RESET_VECTOR;
      target_q <= 32'd0;
      active_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      target_q <= target_d;
      active_q <= active_d;
    end
  end

  assign pc_if.pc         = pc_q;
  assign pc_if.PCplus4    = pc_plus4;
  assign pc_if.delay_slot = (state_q == DELAY);
  assign pc_if.active     = active_q;

endmodule
